// File: rtl/arb_mux_n.sv
// arb_mux_n: NCH-input arbitrating multiplexer with a single registered output slot.
// MODE=0 selects the channel by SEL; MODE=1 uses a round-robin search that starts
// after the last granted channel.
// The optional out-of-range-select check on ERR is enabled by defining ARB_MUX_N_SELCHK_EN.
module arb_mux_n #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*WIDTH-1:0] I,
  input  logic [NCH-1:0]       I_valid,
  output logic [NCH-1:0]       I_ready,
  input  logic                 MODE,
  input  logic [SELW-1:0]      SEL,
  output logic [WIDTH-1:0]     O,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [SELW-1:0]      GNT,
  output logic                 ERR
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] data_sel;
  logic             hit;
  logic             free;
  logic             xfer;
  int unsigned      cand;

  assign free = !O_valid || O_ready;

  // Pick the granted channel, qualify it with slot space and reset, and mux its data
  always_comb begin
    hit      = 1'b0;
    gnt_idx  = '0;
    data_sel = '0;
    I_ready  = '0;
    cand     = 0;
    if (!MODE) begin
      // An out-of-range SEL matches no channel, so nothing is granted
      for (int unsigned k = 0; k < NCH; k++) begin
        if (SEL == SELW'(k)) begin
          hit     = I_valid[k];
          gnt_idx = SELW'(k);
        end
      end
    end else begin
      // Offsets 1..NCH from ptr; the first valid channel found wins
      for (int unsigned off = 1; off <= NCH; off++) begin
        cand = 32'(ptr) + off;
        if (cand >= NCH) cand = cand - NCH;
        if (!hit && I_valid[cand]) begin
          hit     = 1'b1;
          gnt_idx = SELW'(cand);
        end
      end
    end
    xfer = hit && free && !RST;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (gnt_idx == SELW'(k)) begin
        data_sel   = I[k*WIDTH +: WIDTH];
        I_ready[k] = xfer;
      end
    end
  end

  // Output slot: load on transfer, drain when accepted with nothing to load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      O       <= '0;
      O_valid <= 1'b0;
      GNT     <= '0;
      ptr     <= SELW'(NCH - 1);
    end else if (xfer) begin
      O       <= data_sel;
      GNT     <= gnt_idx;
      O_valid <= 1'b1;
      if (MODE) ptr <= gnt_idx;
    end else if (O_ready) begin
      O_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_N_SELCHK_EN
  logic sel_oor;
  assign sel_oor = 32'(SEL) >= NCH;

  // Sticky flag: fixed mode pointed outside the channel range while a channel requested
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (!MODE && sel_oor && (|I_valid)) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data bits per channel (legal 1..64).
REQ-002 The block SHALL have parameter NCH, default 4, meaning input channel count (legal 2..8).
REQ-003 The block SHALL have parameter SELW, default 3, meaning SEL width (SELW >= clog2(NCH)).
REQ-004 CLK  input  1  sole clock, all state on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 I  input  NCH*WIDTH  channel data, flat; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 I_valid  input  NCH  per-channel valid.
REQ-008 I_ready  output  NCH  per-channel ready, combinational.
REQ-009 MODE  input  1  0 = fixed select by SEL, 1 = round-robin.
REQ-010 SEL  input  SELW  channel index used when MODE=0.
REQ-011 O  output  WIDTH  registered output data.
REQ-012 O_valid  output  1  O holds valid data.
REQ-013 O_ready  input  1  downstream accepts O this cycle.
REQ-014 GNT  output  SELW  index of channel currently held in O.
REQ-015 ERR  output  1  sticky out-of-range-select flag (see Configuration).

Function
REQ-016 Output stage SHALL be one register slot; slot "free" = !O_valid || O_ready.
REQ-017 Granted channel g SHALL be chosen combinationally each cycle; I_ready[g] = free && I_valid[g]; all other I_ready bits 0.
REQ-018 Transfer on channel g SHALL occur when I_valid[g] && I_ready[g]; next edge: O <= channel g data, GNT <= g, O_valid <= 1.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to O_valid.
REQ-020 Free slot with no transfer and O_ready=1 SHALL clear O_valid next edge; O and GNT hold last values.
REQ-021 While O_valid && !O_ready, O and GNT SHALL hold stable and all I_ready SHALL be 0.
REQ-022 Simultaneous drain and fill (O_valid, O_ready, transfer) SHALL load new data with O_valid staying 1 (full throughput, 1 word/cycle).
REQ-023 MODE=0: g = SEL; SEL >= NCH SHALL grant nothing (all I_ready 0, no transfer).
REQ-024 MODE=1: g = first channel with I_valid set searching cyclically from PTR+1, wrapping NCH-1 -> 0; no valid channel = no grant.
REQ-025 Round-robin pointer PTR SHALL update to g only on a transfer in MODE=1; MODE=0 transfers SHALL NOT change PTR.
REQ-026 MODE/SEL changes SHALL take effect the same cycle; held O data unaffected.

Reset
REQ-027 RST high SHALL asynchronously force O=0, O_valid=0, GNT=0, ERR=0, PTR=NCH-1 (so first round-robin search starts at channel 0).
REQ-028 RST asserted mid-transfer SHALL discard the held word; no transfer SHALL occur while RST is high (I_ready=0).
REQ-029 Operation SHALL resume on the first rising edge after RST deasserts.

Configuration
REQ-030 Macro ARB_MUX_N_SELCHK_EN defined: ERR SHALL set on any edge where MODE=0, SEL >= NCH and any I_valid bit is 1, and remain set until RST.
REQ-031 Macro undefined: ERR port SHALL remain present and be driven constant 0; no check logic synthesised.

Verification
REQ-032 NCH=4, MODE=0, SEL=2, I_valid=4'b0100, ch2=16'hBEEF, O_ready=1 -> next cycle O=16'hBEEF, O_valid=1, GNT=2.
REQ-033 MODE=1, I_valid=4'b1111 held, O_ready=1 from reset -> GNT sequence 0,1,2,3,0 on consecutive cycles, O_valid continuously 1.
REQ-034 MODE=1, I_valid=4'b1001, PTR=3 -> grant 0; next grant 3; wrap 3->0 verified.
REQ-035 O_valid=1, O_ready=0 for 3 cycles with ch1 valid -> O stable, I_ready=0 all 3 cycles; O_ready=1 -> ch1 loaded next edge.
REQ-036 MODE=0, SEL=5, I_valid=4'b0001 -> I_ready=0, O_valid unchanged; ERR=1 next edge with macro, ERR=0 without.
REQ-037 RST pulsed while O_valid=1, O=16'h1234 -> O=0, O_valid=0, GNT=0 immediately, before next clock edge.
